// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: opcodes, FSM states and instruction field helpers for cpu_multicycle.
package cpu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_SUBI = 4'h5,
        OP_BEQ  = 4'h6,
        OP_MUL  = 4'h7,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

    // Word layout from the top: opcode, WA, RA1, RA2, imm.
    function automatic logic [3:0] op_of(input logic [63:0] ir, input int iw);
        return 4'(ir >> (iw - 4));
    endfunction

    function automatic logic [31:0] wa_of(input logic [63:0] ir, input int rw, input int dw);
        return 32'(ir >> (dw + 2 * rw));
    endfunction

    function automatic logic [31:0] ra1_of(input logic [63:0] ir, input int rw, input int dw);
        return 32'(ir >> (dw + rw));
    endfunction

    function automatic logic [31:0] ra2_of(input logic [63:0] ir, input int dw);
        return 32'(ir >> dw);
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// cpu_mc_regfile: 2**ADDR_W x DATA_W registers, two async reads, one sync write, sync clear.
module cpu_mc_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] r [2**ADDR_W];

    assign rd1 = r[ra1];
    assign rd2 = r[ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) r[i] <= '0;
        end else if (we) begin
            r[wa] <= wd;
        end
    end
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: 4-state multi-cycle core with req/ack instruction fetch.
// Define CPU_MUL_EN to make opcode 7 a multiply; otherwise it is a NOP.
module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 4,
    parameter int PC_W       = 8,
    localparam int INSTR_W   = 4 + 3 * REG_ADDR_W + DATA_W
) (
    input  logic               CLK,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [DATA_W-1:0]  ALUResult,
    output logic [DATA_W-1:0]  cpu_out,
    output logic               retire,
    output logic               halted
);
    state_e                state;
    opcode_e               op;
    logic [PC_W-1:0]       pc;
    logic [INSTR_W-1:0]    ir;
    logic [DATA_W-1:0]     a, b, rd1, rd2, alu, imm;
    logic [REG_ADDR_W-1:0] wa, ra1, ra2;
    logic                  zero, we, writes;

    assign op        = opcode_e'(op_of(64'(ir), INSTR_W));
    assign wa        = REG_ADDR_W'(wa_of(64'(ir), REG_ADDR_W, DATA_W));
    assign ra1       = REG_ADDR_W'(ra1_of(64'(ir), REG_ADDR_W, DATA_W));
    assign ra2       = REG_ADDR_W'(ra2_of(64'(ir), DATA_W));
    assign imm       = DATA_W'(ir);
    assign imem_addr = pc;
    assign we        = state == S_WB && writes;

`ifdef CPU_MUL_EN
    assign writes = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI, OP_MUL};
`else
    assign writes = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI};
`endif

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:         alu = a + b;
            OP_SUB, OP_BEQ: alu = a - b;
            OP_AND:         alu = a & b;
            OP_OR:          alu = a | b;
            OP_ADDI:        alu = a + imm;
            OP_SUBI:        alu = a - imm;
`ifdef CPU_MUL_EN
            OP_MUL:         alu = a * b;
`endif
            default:        alu = '0;
        endcase
    end

    cpu_mc_regfile #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W)) u_rf (
        .clk(CLK), .rst(reset), .we(we), .wa(wa), .ra1(ra1), .ra2(ra2),
        .wd(ALUResult), .rd1(rd1), .rd2(rd2)
    );

    // The first fetch after reset spends one cycle raising imem_req; later fetches
    // have it raised on the way out of S_WB so back-to-back acks give 4 cycles/instr.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            zero      <= 1'b0;
            ALUResult <= '0;
            cpu_out   <= '0;
            imem_req  <= 1'b0;
            retire    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rd1;
                    b     <= rd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    ALUResult <= alu;
                    zero      <= alu == '0;
                    retire    <= 1'b1;
                    state     <= S_WB;
                end
                S_WB: begin
                    if (writes) cpu_out <= ALUResult;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc       <= (op == OP_BEQ && zero) ? pc + PC_W'($signed(imm)) : pc + PC_W'(1);
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs with a retire scoreboard; honours CPU_MUL_EN.
module tb_cpu_multicycle;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [7:0]  imem_addr, ALUResult, cpu_out;
    logic [23:0] imem_rdata = '0;
    logic        retire, halted;

    typedef struct {
        logic [7:0] pc, alu, cout, npc;
        int         gap;
        logic       hlt;
    } exp_t;

    exp_t        q[$];
    logic [23:0] mem [256];
    int          dly [256];
    int          tests = 0, fails = 0, cyc = 0, last = 0;

`ifdef CPU_MUL_EN
    localparam logic [7:0] MULR = 8'h04, C10 = 8'h04;
`else
    localparam logic [7:0] MULR = 8'h00, C10 = 8'h14;
`endif

    cpu_multicycle dut (
        .CLK(CLK), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ALUResult(ALUResult),
        .cpu_out(cpu_out), .retire(retire), .halted(halted)
    );

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Instruction memory: acks after dly[addr] extra cycles of an outstanding request.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (imem_req === 1'b1) begin
                if (cnt >= dly[imem_addr]) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    cnt        = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    function automatic logic [23:0] enc(input logic [3:0] op, wa, ra1, ra2, input logic [7:0] imm);
        return {op, wa, ra1, ra2, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] pc, alu, cout, npc, input int gap, input logic hlt);
        q.push_back('{pc: pc, alu: alu, cout: cout, npc: npc, gap: gap, hlt: hlt});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", imem_req, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_alu", ALUResult, 0);
        chk("rst_cpu_out", cpu_out, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b0;
        last  = cyc;
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            e = q.pop_front();
            while (retire !== 1'b1 && w < 100) begin
                @(negedge CLK);
                w++;
            end
            chk("retire_seen", 32'(retire), 1);
            chk("retire_pc", imem_addr, e.pc);
            chk("alu", ALUResult, e.alu);
            chk("retire_gap", cyc - last, e.gap);
            last = cyc;
            @(negedge CLK);
            chk("cpu_out", cpu_out, e.cout);
            chk("next_pc", imem_addr, e.npc);
            chk("halted", halted, e.hlt);
            chk("req_after_wb", imem_req, !e.hlt);
            chk("retire_pulse", retire, 0);
        end
    endtask

    initial begin
        int hits = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = enc(4'hF, 0, 0, 0, 0);
            dly[i] = 0;
        end
        // Program A: ALU ops, a stalled fetch, opcode 7, NOP and HALT
        mem[0]  = enc(4, 1, 0, 0, 8'd5);
        mem[1]  = enc(4, 2, 0, 0, 8'd3);
        mem[2]  = enc(1, 3, 1, 2, 0);
        mem[3]  = enc(0, 4, 1, 2, 0);
        mem[4]  = enc(2, 5, 1, 2, 0);
        mem[5]  = enc(3, 6, 1, 2, 0);
        mem[6]  = enc(5, 7, 2, 0, 8'd4);
        mem[7]  = enc(4, 8, 7, 0, 8'd2);
        mem[8]  = enc(4, 10, 0, 0, 8'd13);
        mem[9]  = enc(4, 11, 0, 0, 8'd20);
        mem[10] = enc(7, 9, 10, 11, 0);
        mem[11] = enc(0, 12, 9, 0, 0);
        mem[12] = enc(8, 13, 1, 2, 8'h55);
        mem[13] = enc(4'hF, 14, 1, 2, 8'h11);
        dly[7]  = 3;
        @(negedge CLK);
        do_reset();
        push(0, 8'h05, 8'h05, 1, 4, 0);
        push(1, 8'h03, 8'h03, 2, 4, 0);
        push(2, 8'h02, 8'h02, 3, 4, 0);
        push(3, 8'h08, 8'h08, 4, 4, 0);
        push(4, 8'h01, 8'h01, 5, 4, 0);
        push(5, 8'h07, 8'h07, 6, 4, 0);
        push(6, 8'hFF, 8'hFF, 7, 4, 0);
        drain(7);
        repeat (2) begin
            @(negedge CLK);
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, 7);
        end
        push(7,  8'h01, 8'h01, 8,  7, 0);
        push(8,  8'h0D, 8'h0D, 9,  4, 0);
        push(9,  8'h14, 8'h14, 10, 4, 0);
        push(10, MULR,  C10,   11, 4, 0);
        push(11, MULR,  MULR,  12, 4, 0);
        push(12, 8'h00, MULR,  13, 4, 0);
        push(13, 8'h00, MULR,  13, 4, 1);
        drain(7);
        // Program B: BEQ taken/not taken, PC wrap, ADDI overflow, reset mid-fetch
        for (int i = 0; i < 256; i++) dly[i] = 0;
        mem[0]     = enc(4, 1, 0, 0, 8'd7);
        mem[1]     = enc(4, 2, 0, 0, 8'd8);
        mem[2]     = enc(5, 2, 2, 0, 8'd1);
        mem[3]     = enc(9, 0, 0, 0, 0);
        mem[4]     = enc(6, 0, 1, 2, 8'hFE);
        mem[5]     = enc(6, 0, 0, 0, 8'hF8);
        mem[8'hFD] = enc(4, 5, 0, 0, 8'hFF);
        mem[8'hFE] = enc(4, 6, 5, 0, 8'h01);
        mem[8'hFF] = enc(4'hE, 0, 0, 0, 0);
        do_reset();
        push(0, 8'h07, 8'h07, 1, 4, 0);
        push(1, 8'h08, 8'h08, 2, 4, 0);
        push(2, 8'h07, 8'h07, 3, 4, 0);
        push(3, 8'h00, 8'h07, 4, 4, 0);
        push(4, 8'h00, 8'h07, 2, 4, 0);
        push(2, 8'h06, 8'h06, 3, 4, 0);
        push(3, 8'h00, 8'h06, 4, 4, 0);
        push(4, 8'h01, 8'h06, 5, 4, 0);
        push(5, 8'h00, 8'h06, 8'hFD, 4, 0);
        drain(9);
        dly[2] = 20;
        push(8'hFD, 8'hFF, 8'hFF, 8'hFE, 4, 0);
        push(8'hFE, 8'h00, 8'h00, 8'hFF, 4, 0);
        push(8'hFF, 8'h00, 8'h00, 8'h00, 4, 0);
        push(0, 8'h07, 8'h07, 1, 4, 0);
        push(1, 8'h08, 8'h08, 2, 4, 0);
        drain(5);
        @(negedge CLK);
        chk("midfetch_req", imem_req, 1);
        // Program C: registers must read back as zero after the mid-fetch reset
        mem[0] = enc(0, 7, 2, 5, 0);
        mem[1] = enc(4'hF, 0, 0, 0, 0);
        dly[2] = 0;
        do_reset();
        push(0, 8'h00, 8'h00, 1, 4, 0);
        push(1, 8'h00, 8'h00, 1, 4, 1);
        drain(2);
        repeat (10) begin
            @(negedge CLK);
            if (imem_req !== 1'b0) hits++;
        end
        chk("halt_no_req", hits, 0);
        chk("halt_stays", halted, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
